// File: rtl/lc3_pipe_controller.sv
// Central sequencer for the LC3 five-stage pipeline: stage enables, memory-access FSM,
// branch squash and execute bypass selects. Optional stall counter: LC3_CTRL_STALL_STATS_EN.
module lc3_pipe_controller #(
  parameter int FILL_DEPTH  = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] Imem_dout,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
`ifdef LC3_CTRL_STALL_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  localparam int FW = $clog2(FILL_DEPTH + 1);

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_READ_IND = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_e;

  mem_state_e    mem_q, mem_d;
  logic          ind_st_q, ind_st_d;
  logic          post_q, post_d;
  logic          post_ld_q, post_ld_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          wb_base_q;
  logic [1:0]    sq_q, sq_d;

  logic [3:0] op_ex, op_id;
  logic       idle;
  logic       ex_alu, id_alu, ex_ld, src1_hit, src2_hit, running;
  logic       unused_bits;

  assign op_ex       = IR_Exec[15:12];
  assign op_id       = IR[15:12];
  assign unused_bits = ^{IR[4:3], IR_Exec[8:0], Imem_dout};

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q     <= MEM_IDLE;
      ind_st_q  <= 1'b0;
      post_q    <= 1'b0;
      post_ld_q <= 1'b0;
      fill_q    <= '0;
      wb_base_q <= 1'b0;
      sq_q      <= '0;
    end else begin
      mem_q     <= mem_d;
      ind_st_q  <= ind_st_d;
      post_q    <= post_d;
      post_ld_q <= post_ld_d;
      fill_q    <= fill_d;
      // writeback follows execute by one cycle once the fill counter saturates
      wb_base_q <= wb_base_q | (fill_q == FW'(FILL_DEPTH));
      sq_q      <= sq_d;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    ind_st_d  = ind_st_q;
    post_d    = 1'b0;
    post_ld_d = 1'b0;
    fill_d    = (fill_q == FW'(FILL_DEPTH)) ? fill_q : fill_q + FW'(1);
    sq_d      = br_taken ? 2'd3 : ((sq_q != 2'd0) ? sq_q - 2'd1 : 2'd0);
    case (mem_q)
      MEM_IDLE: begin
        if (enable_execute) begin
          case (op_ex)
            4'b0010, 4'b0110: mem_d = MEM_READ;
            4'b1010: begin mem_d = MEM_READ_IND; ind_st_d = 1'b0; end
            4'b1011: begin mem_d = MEM_READ_IND; ind_st_d = 1'b1; end
            4'b0011, 4'b0111: mem_d = MEM_WRITE;
            default: mem_d = MEM_IDLE;
          endcase
        end
      end
      MEM_READ_IND: begin
        if (complete_data) mem_d = ind_st_q ? MEM_WRITE : MEM_READ;
      end
      default: begin
        if (complete_data) begin
          mem_d     = MEM_IDLE;
          post_d    = 1'b1;
          post_ld_d = (mem_q == MEM_READ);
        end
      end
    endcase
  end

  always_comb begin
    idle      = (mem_q == MEM_IDLE);
    running   = (fill_q != '0);
    mem_state = mem_q;

    enable_updatePC  = running & idle & complete_instr;
    enable_fetch     = running & idle & complete_instr;
    enable_decode    = (fill_q >= FW'(FILL_DEPTH - 1)) & idle & complete_instr & (sq_q != 2'd3);
    enable_execute   = (fill_q >= FW'(FILL_DEPTH)) & idle & complete_instr & ~sq_q[1];
    enable_writeback = idle & (post_q ? post_ld_q : (wb_base_q & (sq_q == 2'd0)));

    br_taken = enable_execute &
               (((op_ex == 4'b0000) & (|(IR_Exec[11:9] & psr))) | (op_ex == 4'b1100));

    ex_alu   = op_ex inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
    id_alu   = op_id inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
    ex_ld    = op_ex inside {4'b0010, 4'b0110, 4'b1010};
    src1_hit = running & id_alu & (IR[8:6] == IR_Exec[11:9]);
    src2_hit = src1_hit & (op_id inside {4'b0001, 4'b0101}) & ~IR[5] &
               (IR[2:0] == IR_Exec[11:9]);

    bypass_alu_1 = ex_alu & src1_hit;
    bypass_alu_2 = ex_alu & src2_hit;
    bypass_mem_1 = idle & ex_ld & src1_hit;
    bypass_mem_2 = idle & ex_ld & src2_hit;
  end

`ifdef LC3_CTRL_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((!idle || !complete_instr) && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller: directed scenarios then random traffic,
// every cycle compared against a queue/cycle-age reference model.
module tb_lc3_pipe_controller;

  logic        clock = 1'b0;
  logic        reset, complete_data, complete_instr;
  logic [15:0] IR, IR_Exec, Imem_dout;
  logic [2:0]  psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;
`ifdef LC3_CTRL_STALL_STATS_EN
  logic [15:0] stall_count;
`endif

  lc3_pipe_controller #(.FILL_DEPTH(3), .STALL_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .complete_data(complete_data),
    .complete_instr(complete_instr), .IR(IR), .IR_Exec(IR_Exec), .Imem_dout(Imem_dout),
    .psr(psr), .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .mem_state(mem_state)
`ifdef LC3_CTRL_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: c = edges since reset released, br_age = edges since a taken
  // branch, mq = remaining memory phases of the op in flight (empty = idle).
  int c, br_age, stall_m;
  int mq[$];
  bit post_v, post_ld;
  bit m_idle, m_ex, m_br;

  function automatic bit is_alu(input logic [3:0] op);
    return op inside {4'h1, 4'h5, 4'h9, 4'hE};
  endfunction

  function automatic bit is_ld(input logic [3:0] op);
    return op inside {4'h2, 4'h6, 4'hA};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e_fe, e_de, e_wb, s1, s2, a1, a2, l1, l2;
    logic [1:0] e_ms;
    m_idle = (mq.size() == 0);
    e_fe = (c >= 1) && m_idle && complete_instr;
    e_de = (c >= 2) && m_idle && complete_instr && (br_age != 1);
    m_ex = (c >= 3) && m_idle && complete_instr && !(br_age >= 1 && br_age <= 2);
    if (!m_idle) e_wb = 1'b0;
    else if (post_v) e_wb = post_ld;
    else e_wb = (c >= 4) && !(br_age >= 1 && br_age <= 3);
    m_br = m_ex && (((IR_Exec[15:12] == 4'h0) && ((IR_Exec[11:9] & psr) != 3'b000)) ||
                    (IR_Exec[15:12] == 4'hC));
    e_ms = m_idle ? 2'd3 : 2'(mq[0]);
    s1 = (c >= 1) && is_alu(IR[15:12]) && (IR[8:6] == IR_Exec[11:9]);
    s2 = s1 && (IR[15:12] == 4'h1 || IR[15:12] == 4'h5) && !IR[5] && (IR[2:0] == IR_Exec[11:9]);
    a1 = s1 && is_alu(IR_Exec[15:12]);
    a2 = s2 && is_alu(IR_Exec[15:12]);
    l1 = s1 && m_idle && is_ld(IR_Exec[15:12]);
    l2 = s2 && m_idle && is_ld(IR_Exec[15:12]);
    chk("updatePC", 16'(enable_updatePC), 16'(e_fe));
    chk("fetch", 16'(enable_fetch), 16'(e_fe));
    chk("decode", 16'(enable_decode), 16'(e_de));
    chk("execute", 16'(enable_execute), 16'(m_ex));
    chk("writeback", 16'(enable_writeback), 16'(e_wb));
    chk("br_taken", 16'(br_taken), 16'(m_br));
    chk("mem_state", 16'(mem_state), 16'(e_ms));
    chk("byp_alu_1", 16'(bypass_alu_1), 16'(a1));
    chk("byp_alu_2", 16'(bypass_alu_2), 16'(a2));
    chk("byp_mem_1", 16'(bypass_mem_1), 16'(l1));
    chk("byp_mem_2", 16'(bypass_mem_2), 16'(l2));
`ifdef LC3_CTRL_STALL_STATS_EN
    chk("stall_count", stall_count, 16'(stall_m));
`endif
  endtask

  task automatic model_edge();
    int p;
    if (reset) begin
      c = 0; br_age = 99; stall_m = 0; post_v = 0; post_ld = 0;
      mq.delete();
      return;
    end
    if ((!m_idle || !complete_instr) && stall_m < 65535) stall_m++;
    post_v = 0;
    if (!m_idle && complete_data) begin
      p = mq.pop_front();
      if (mq.size() == 0) begin post_v = 1; post_ld = (p == 0); end
    end else if (m_idle && m_ex) begin
      case (IR_Exec[15:12])
        4'h2, 4'h6: mq.push_back(0);
        4'hA: begin mq.push_back(1); mq.push_back(0); end
        4'hB: begin mq.push_back(1); mq.push_back(2); end
        4'h3, 4'h7: mq.push_back(2);
        default: ;
      endcase
    end
    br_age = m_br ? 1 : ((br_age < 99) ? br_age + 1 : br_age);
    if (c < 99) c++;
  endtask

  // one clock: compare at mid-cycle, advance model at the edge, resume just after it
  task automatic cyc();
    #2;
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b1; complete_data = 1'b0; complete_instr = 1'b1;
    IR = 16'h0000; IR_Exec = 16'h0000; Imem_dout = 16'h0000; psr = 3'b010;
    @(posedge clock); model_edge(); #1;
    cyc();
    chk("rst_mem_state", 16'(mem_state), 16'd3);
    chk("rst_fetch", 16'(enable_fetch), 16'd0);

    // pipeline fill with NOPs
    reset = 1'b0;
    cyc(); chk("fill1_fetch", 16'(enable_fetch), 16'd1);
    chk("fill1_decode", 16'(enable_decode), 16'd0);
    cyc(); chk("fill2_decode", 16'(enable_decode), 16'd1);
    chk("fill2_execute", 16'(enable_execute), 16'd0);
    cyc(); chk("fill3_execute", 16'(enable_execute), 16'd1);
    chk("fill3_wb", 16'(enable_writeback), 16'd0);
    cyc(); chk("fill4_wb", 16'(enable_writeback), 16'd1);
    repeat (2) cyc();

    // LDR with completion after three waiting cycles
    IR_Exec = 16'h6A40; cyc();
    IR_Exec = 16'h0000;
    chk("ldr_state", 16'(mem_state), 16'd0);
    repeat (3) cyc();
    chk("ldr_hold_fetch", 16'(enable_fetch), 16'd0);
    complete_data = 1'b1; cyc(); complete_data = 1'b0;
    chk("ldr_done_state", 16'(mem_state), 16'd3);
    chk("ldr_wb_pulse", 16'(enable_writeback), 16'd1);
    repeat (2) cyc();

    // STI: indirect read then write, no writeback pulse
    IR_Exec = 16'hB605; cyc();
    IR_Exec = 16'h0000;
    chk("sti_ind", 16'(mem_state), 16'd1);
    complete_data = 1'b1; cyc(); complete_data = 1'b0;
    chk("sti_write", 16'(mem_state), 16'd2);
    cyc();
    complete_data = 1'b1; cyc(); complete_data = 1'b0;
    chk("sti_idle", 16'(mem_state), 16'd3);
    chk("sti_no_wb", 16'(enable_writeback), 16'd0);
    repeat (2) cyc();

    // BRz taken with Z set, then not taken with N only
    IR_Exec = 16'h0403; psr = 3'b010; #1;
    chk("brz_taken", 16'(br_taken), 16'd1);
    cyc(); IR_Exec = 16'h0000;
    chk("sq1_decode", 16'(enable_decode), 16'd0);
    chk("sq1_fetch", 16'(enable_fetch), 16'd1);
    repeat (4) cyc();
    IR_Exec = 16'h0403; psr = 3'b100; #1;
    chk("brz_not_taken", 16'(br_taken), 16'd0);
    cyc(); IR_Exec = 16'h0000;
    repeat (2) cyc();

    // bypass: ALU producer then load producer
    IR = 16'h1641; IR_Exec = 16'h1262; #1;
    chk("alu_byp1", 16'(bypass_alu_1), 16'd1);
    chk("alu_byp2", 16'(bypass_alu_2), 16'd1);
    cyc();
    IR_Exec = 16'h2205; #1;
    chk("mem_byp1", 16'(bypass_mem_1), 16'd1);
    chk("mem_byp2", 16'(bypass_mem_2), 16'd1);
    chk("mem_no_alu1", 16'(bypass_alu_1), 16'd0);
    cyc(); IR_Exec = 16'h0000; IR = 16'h0000;
    complete_data = 1'b1; cyc(); complete_data = 1'b0;
    cyc();

`ifdef LC3_CTRL_STALL_STATS_EN
    reset = 1'b1; cyc(); reset = 1'b0;
    complete_instr = 1'b0; repeat (5) cyc(); complete_instr = 1'b1;
    chk("stall_5", stall_count, 16'd5);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("stall_clr", stall_count, 16'd0);
    repeat (4) cyc();
`endif

    // random traffic including occasional mid-stall resets
    for (int i = 0; i < 2000; i++) begin
      IR             = 16'($urandom);
      IR_Exec        = 16'($urandom);
      Imem_dout      = 16'($urandom);
      psr            = 3'($urandom);
      complete_instr = ($urandom_range(0, 7) != 0);
      complete_data  = ($urandom_range(0, 2) == 0);
      reset          = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_controller.md
Name: lc3_pipe_controller

Overview:
- Central sequencer for the LC3 five-stage pipeline (fetch, decode, execute, writeback, memaccess).
- Generates per-stage enables, the memory-access state for memaccess, the branch-taken flag, and the ALU/memory bypass selects for execute.
- Consumes the decode-stage instruction, the execute-stage instruction (IR_Exec, as driven on the execute output bus) and the writeback PSR.
- Sits beside the datapath; it is the only source of stage enables.

Parameters:
- FILL_DEPTH, 3, cycles after reset before all four stage enables reach steady state (fetch→writeback distance).
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- complete_data  input  1  data memory access finished this cycle
- complete_instr  input  1  instruction memory returned valid data
- IR  input  16  instruction in decode stage
- IR_Exec  input  16  instruction in execute stage
- Imem_dout  input  16  instruction word from instruction memory
- psr  input  3  N/Z/P flags from writeback
- enable_updatePC  output  1  PC register update
- enable_fetch  output  1  fetch stage enable
- enable_decode  output  1  decode stage enable
- enable_execute  output  1  execute stage enable
- enable_writeback  output  1  writeback stage enable
- br_taken  output  1  redirect PC to execute target
- bypass_alu_1  output  1  forward aluout to execute source 1
- bypass_alu_2  output  1  forward aluout to execute source 2
- bypass_mem_1  output  1  forward memout to execute source 1
- bypass_mem_2  output  1  forward memout to execute source 2
- mem_state  output  2  0=READ, 1=READ_IND, 2=WRITE, 3=IDLE

Behaviour:
- Reset (synchronous):
  - All enables, br_taken and bypasses = 0.
  - mem_state = 3.
  - Fill counter = 0.
- Pipeline fill:
  - 1st cycle after reset deasserts: enable_updatePC = enable_fetch = 1.
  - 2nd cycle: enable_decode = 1. 3rd cycle: enable_execute = 1. 4th cycle: enable_writeback = 1.
  - Counter saturates at FILL_DEPTH.
- Instruction-memory stall:
  - complete_instr = 0 → enable_updatePC, enable_fetch, enable_decode, enable_execute = 0 for that cycle.
- Memory FSM:
  - Evaluated at a rising edge where enable_execute = 1 and mem_state = IDLE, using IR_Exec[15:12]:
    - LD (0010) / LDR (0110) → READ.
    - LDI (1010) / STI (1011) → READ_IND.
    - ST (0011) / STR (0111) → WRITE.
    - Any other opcode → stay IDLE.
  - READ or WRITE: hold until complete_data = 1, then → IDLE.
  - READ_IND: on complete_data = 1 → READ (LDI) or WRITE (STI).
  - complete_data with mem_state = IDLE is ignored.
- Enables while mem_state ≠ IDLE:
  - enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback = 0.
  - enable_writeback pulses 1 for exactly the cycle after the READ→IDLE transition (loads only).
  - Store completion produces no writeback pulse.
- Branch resolution (combinational, qualified by enable_execute = 1):
  - br_taken = 1 if (IR_Exec[15:12] == 0000 and |(IR_Exec[11:9] & psr)), or IR_Exec[15:12] == 1100.
  - On br_taken, squash via bubble counter:
    - enable_decode = 0 for the next 1 cycle.
    - enable_execute = 0 for the next 2 cycles.
    - enable_writeback = 0 for the next 3 cycles.
    - enable_updatePC and enable_fetch stay 1.
  - A second br_taken is impossible while squashing, because execute is disabled.
- Bypass (combinational):
  - Define ALU ops = ADD 0001, AND 0101, NOT 1001, LEA 1110. Define LD-type = LD, LDR, LDI.
  - bypass_alu_1 = IR_Exec is an ALU op, IR is an ALU op, and IR[8:6] == IR_Exec[11:9].
  - bypass_alu_2 = same conditions, plus IR[15:12] ∈ {ADD, AND}, IR[5] = 0, and IR[2:0] == IR_Exec[11:9].
  - bypass_mem_1 / bypass_mem_2 use the same matching rules, except IR_Exec must be LD-type.
  - mem bypasses are valid only when mem_state = IDLE; otherwise 0.
  - alu and mem bypasses are never both 1 for the same source.
- Simultaneous events:
  - Memory-FSM entry has priority over the br_taken squash. Not reachable: a memory op is not a branch.
  - reset overrides everything, including mid-stall: mem_state → IDLE and the fill restarts.

Optional Feature:
- Macro: LC3_CTRL_STALL_STATS_EN.
- Defined:
  - Adds output stall_count [STALL_CNT_W-1:0].
  - Increments every cycle mem_state ≠ IDLE or complete_instr = 0.
  - Saturates at all-ones; cleared by reset.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset release, complete_instr = 1, NOP stream → updatePC/fetch high at cycle 1, decode at 2, execute at 3, writeback at 4; mem_state stays 3.
- IR_Exec = LDR (0x6A40), complete_data held low 3 cycles then high → mem_state = 0 for 4 cycles; all enables 0; then 3; enable_writeback = 1 one cycle.
- IR_Exec = STI (0xB605), complete_data pulses twice → mem_state 3→1→2→3; no writeback pulse.
- IR_Exec = BRz (0x0403), psr = 010 → br_taken = 1; decode low 1 cycle, execute low 2, writeback low 3. With psr = 100 → br_taken = 0.
- IR_Exec = ADD R1 (0x1262), IR = ADD R3,R1,R1 (0x1641) → bypass_alu_1 = bypass_alu_2 = 1. With IR_Exec = LD R1 (0x2205) → bypass_mem_1 = bypass_mem_2 = 1, alu bypasses = 0.
- LC3_CTRL_STALL_STATS_EN defined, 5 stall cycles then reset → stall_count = 5, then 0 after reset.
